sad_block_engine: RTL and testbench

Downstream consumer of the serial GPIO receive path. When the receive RAM signals full, the engine walks the RAM through the shared 9-bit read address and reads two equal-length pixel blocks, A and B. It accumulates the sum of absolute differences (SAD) between them and presents the result with a one-cycle done pulse. This is the first compute stage of the SAD processor.

---
 rtl/sad_block_engine.sv | 153 +++++++++++++++
 tb/tb_sad_block_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_block_engine.sv
// Walks the receive RAM on a ram_full rising edge and accumulates SAD between blocks A and B.
// Latency: 2N+2 cycles from the sampled ram_full edge to the done pulse.
// Backpressure: none; ram_full edges seen while a run is in progress are dropped, not queued.
module sad_block_engine #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 9,
    parameter int N      = 64,
    parameter int SAD_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_full,
    input  logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic [SAD_W-1:0]  sad
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
    localparam logic [ADDR_W-1:0] B_BASE   = ADDR_W'(N);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic               ram_full_q, ram_full_d;
    logic               phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [SAD_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SAD_W-1:0]   sad_q, sad_d;

    logic               start;
    logic [WIDTH:0]     a_ext;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     abs_diff;
    logic [SAD_W:0]     acc_sum;
    logic [SAD_W-1:0]   acc_next;

    // Only a fresh edge seen while idle launches a run.
    assign start = ram_full & ~ram_full_q & (state_q == IDLE);

    // |A - B| against the current read data, added with a sticky all-ones clamp on carry-out.
    always_comb begin
        a_ext    = {1'b0, a_q};
        b_ext    = {1'b0, rd_data};
        abs_diff = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);
        acc_sum  = {1'b0, acc_q} + {{(SAD_W - WIDTH){1'b0}}, abs_diff};
        acc_next = acc_sum[SAD_W] ? {SAD_W{1'b1}} : acc_sum[SAD_W-1:0];
    end

    // Next-state logic: the RUN phase bit alternates A-address and B-address cycles.
    always_comb begin
        state_d    = state_q;
        ram_full_d = ram_full;
        phase_d    = phase_q;
        idx_d      = idx_q;
        a_d        = a_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sad_d      = sad_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    phase_d = 1'b0;
                    idx_d   = '0;
                    acc_d   = '0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (!phase_q) begin
                    // rd_data holds B[idx-1] here, paired with the A captured last cycle.
                    if (idx_q != '0) begin
                        acc_d = acc_next;
                    end
                    phase_d = 1'b1;
                    addr_d  = B_BASE + ADDR_W'(idx_q);
                end else begin
                    a_d = rd_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        phase_d = 1'b0;
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = ADDR_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            DRAIN: begin
                // Last B word arrives one cycle after its address; fold it in and publish.
                acc_d   = acc_next;
                sad_d   = acc_next;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ram_full_q <= 1'b0;
            phase_q    <= 1'b0;
            idx_q      <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sad_q      <= '0;
        end else begin
            state_q    <= state_d;
            ram_full_q <= ram_full_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sad_q      <= sad_d;
        end
    end

    assign addr = addr_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sad  = sad_q;

endmodule

// File: tb/tb_sad_block_engine.sv
// Bench for sad_block_engine: table of block patterns plus reset/edge corner sequences.
// Two instances share one RAM image: 16-bit result and a 12-bit result that saturates.
// The RAM model returns data one cycle after the address, like the real registered read.
module tb_sad_block_engine;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 9;
    localparam int N      = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              ram_full;
    logic [WIDTH-1:0]  rd0, rd1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic              busy0, busy1, done0, done1;
    logic [15:0]       sad0;
    logic [11:0]       sad1;

    logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];

    sad_block_engine #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .N(N), .SAD_W(16)) dut16 (
        .clk(clk), .rst(rst), .ram_full(ram_full), .rd_data(rd0),
        .addr(addr0), .busy(busy0), .done(done0), .sad(sad0));

    sad_block_engine #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .N(N), .SAD_W(12)) dut12 (
        .clk(clk), .rst(rst), .ram_full(ram_full), .rd_data(rd1),
        .addr(addr1), .busy(busy1), .done(done1), .sad(sad1));

    always @(posedge clk) begin
        rd0 <= mem[addr0];
        rd1 <= mem[addr1];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of |A[i]-B[i]|, clamped to the result width.
    function automatic int model_sad(input int w);
        int total = 0;
        int limit;
        for (int i = 0; i < N; i++) begin
            int a = int'(mem[i]);
            int b = int'(mem[N+i]);
            total += (a > b) ? (a - b) : (b - a);
        end
        limit = (1 << w) - 1;
        return (total > limit) ? limit : total;
    endfunction

    // k-th address of a sweep: A[0], B[0], A[1], B[1], ...
    function automatic int exp_addr(input int k);
        return (k % 2 == 0) ? (k / 2) : (N + k / 2);
    endfunction

    task automatic load_pattern(input int mode);
        for (int i = 0; i < N; i++) begin
            int a;
            int b;
            case (mode)
                0: begin a = i;   b = i;   end
                1: begin a = 0;   b = 255; end
                2: begin a = 255; b = 0;   end
                3: begin a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); end
                default: begin
                    a = int'($urandom_range(0, 255));
                    b = a + int'($urandom_range(0, 6)) - 3;
                    if (b < 0) b = 0;
                    if (b > 255) b = 255;
                end
            endcase
            mem[i]   = WIDTH'(a);
            mem[N+i] = WIDTH'(b);
        end
    endtask

    // One full run from a clean rising edge, checking sweep order, latency and result.
    task automatic run_and_check(input string name, input int e16, input int e12);
        int errs    = 0;
        int done_at = -1;
        int ndone   = 0;
        ram_full = 1'b0;
        tick();
        ram_full = 1'b1;
        for (int k = 1; k <= 2*N + 3; k++) begin
            tick();
            if (k <= 2*N) begin
                if (addr0 !== ADDR_W'(exp_addr(k-1)) || addr1 !== ADDR_W'(exp_addr(k-1)) ||
                    busy0 !== 1'b1 || done0 !== 1'b0)
                    errs++;
            end
            if (k == 2*N + 1 && (busy0 !== 1'b1 || done0 !== 1'b0)) errs++;
            if (done0 === 1'b1) begin
                ndone++;
                done_at = k;
            end
            if (k == 2*N + 2) begin
                check({name, "/sad16"}, 32'(sad0), e16);
                check({name, "/sad12"}, 32'(sad1), e12);
                check({name, "/busy_in_done"}, 32'(busy0), 0);
                check({name, "/done12"}, 32'(done1), 1);
            end
        end
        check({name, "/addr_seq_errors"}, errs, 0);
        check({name, "/done_latency"}, done_at, 2*N + 2);
        check({name, "/done_count"}, ndone, 1);
        check({name, "/sad_held"}, 32'(sad0), e16);
        ram_full = 1'b0;
    endtask

    typedef struct {
        string name;
        int    mode;
        int    exp16;   // -1: take from the reference model after loading
        int    exp12;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int e16;
        int e12;
        int ndone;
        int done_at;
        int found;
        logic [15:0] sad_at_done;

        tbl[0] = '{"ident",      0, 0,     0};
        tbl[1] = '{"a0_b255",    1, 16320, 4095};
        tbl[2] = '{"a255_b0",    2, 16320, 4095};
        tbl[3] = '{"rand_full",  3, -1,    -1};
        tbl[4] = '{"rand_near",  4, -1,    -1};
        tbl[5] = '{"rand_full2", 3, -1,    -1};

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;

        // Reset state
        rst      = 1'b0;
        ram_full = 1'b0;
        repeat (3) tick();
        check("reset/addr", 32'(addr0), 0);
        check("reset/busy", 32'(busy0), 0);
        check("reset/done", 32'(done0), 0);
        check("reset/sad16", 32'(sad0), 0);
        check("reset/sad12", 32'(sad1), 0);
        rst = 1'b1;
        repeat (2) tick();

        // Pattern table
        for (int t = 0; t < 6; t++) begin
            load_pattern(tbl[t].mode);
            e16 = (tbl[t].exp16 < 0) ? model_sad(16) : tbl[t].exp16;
            e12 = (tbl[t].exp12 < 0) ? model_sad(12) : tbl[t].exp12;
            run_and_check(tbl[t].name, e16, e12);
        end

        // ram_full held long, with a re-pulse during the run: one run only
        load_pattern(3);
        e16 = model_sad(16);
        ram_full = 1'b0;
        tick();
        ram_full = 1'b1;
        ndone = 0;
        done_at = -1;
        sad_at_done = '0;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (k == 40)  ram_full = 1'b0;
            if (k == 41)  ram_full = 1'b1;
            if (k == 200) ram_full = 1'b0;
            if (done0 === 1'b1) begin
                ndone++;
                done_at = k;
                sad_at_done = sad0;
            end
        end
        check("hold/done_count", ndone, 1);
        check("hold/done_latency", done_at, 2*N + 2);
        check("hold/sad16", 32'(sad_at_done), e16);
        load_pattern(4);
        run_and_check("after_hold", model_sad(16), model_sad(12));

        // Reset during RUN cycle 50: abort, no done
        load_pattern(3);
        ram_full = 1'b0;
        tick();
        ram_full = 1'b1;
        repeat (50) tick();
        rst      = 1'b0;
        ram_full = 1'b0;
        tick();
        check("midrst/addr", 32'(addr0), 0);
        check("midrst/busy", 32'(busy0), 0);
        check("midrst/done", 32'(done0), 0);
        check("midrst/sad16", 32'(sad0), 0);
        check("midrst/sad12", 32'(sad1), 0);
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done0 === 1'b1 || done1 === 1'b1) ndone++;
        end
        check("midrst/no_done", ndone, 0);
        check("midrst/idle_busy", 32'(busy0), 0);
        load_pattern(3);
        run_and_check("after_midrst", model_sad(16), model_sad(12));

        // ram_full already high when reset releases
        load_pattern(4);
        e16 = model_sad(16);
        e12 = model_sad(12);
        rst      = 1'b0;
        ram_full = 1'b1;
        repeat (2) tick();
        check("rsthigh/busy_in_reset", 32'(busy0), 0);
        rst = 1'b1;
        found = 0;
        ndone = 0;
        sad_at_done = '0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (found == 0 && busy0 === 1'b1) begin
                found = k;
                check("rsthigh/first_addr", 32'(addr0), 0);
            end
            if (done0 === 1'b1) begin
                ndone++;
                sad_at_done = sad0;
            end
        end
        check("rsthigh/start_delay_ok", 32'((found >= 1 && found <= 2) ? 1 : 0), 1);
        check("rsthigh/done_count", ndone, 1);
        check("rsthigh/sad16", 32'(sad_at_done), e16);
        check("rsthigh/sad12", 32'(sad1), e12);
        ram_full = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
